// File: rtl/native_mem_arbiter_if.sv
// rtl/native_mem_arbiter_if.sv - bundle of requester-side and memory-side signals for native_mem_arbiter
//
// Purpose: groups the NUM_REQ upstream request/response lanes and the single
// reg_native memory slave bus into one interface.
// Ports (signals):
//   up_req_vld/up_wr_en/up_rd_en [NUM_REQ]   per-requester command
//   up_addr/up_wr_data (flattened, lane i at [i*W +: W])
//   up_ack_vld/up_err [NUM_REQ], up_rd_data   response to the granted lane
//   req_vld/wr_en/rd_en/addr/wr_data          command to the memory slave
//   ack_vld/rd_data                           completion from the memory slave
// Modports: master = arbiter view (masters the memory bus), slave = environment view.
interface native_mem_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [NUM_REQ-1:0]            up_req_vld;
  logic [NUM_REQ-1:0]            up_wr_en;
  logic [NUM_REQ-1:0]            up_rd_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0] up_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] up_wr_data;
  logic [NUM_REQ-1:0]            up_ack_vld;
  logic [NUM_REQ-1:0]            up_err;
  logic [DATA_WIDTH-1:0]         up_rd_data;
  logic                          req_vld;
  logic                          wr_en;
  logic                          rd_en;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          ack_vld;
  logic [DATA_WIDTH-1:0]         rd_data;

  modport master (
    input  up_req_vld, up_wr_en, up_rd_en, up_addr, up_wr_data, ack_vld, rd_data,
    output up_ack_vld, up_err, up_rd_data, req_vld, wr_en, rd_en, addr, wr_data
  );

  modport slave (
    output up_req_vld, up_wr_en, up_rd_en, up_addr, up_wr_data, ack_vld, rd_data,
    input  up_ack_vld, up_err, up_rd_data, req_vld, wr_en, rd_en, addr, wr_data
  );
endinterface

// File: rtl/native_mem_arbiter.sv
// rtl/native_mem_arbiter.sv - round-robin arbiter sharing one reg_native memory slave
//
// Purpose: grants one of NUM_REQ requesters at a time, issues a single-cycle
// req_vld to the slave, waits for ack_vld (bounded by TIMEOUT cycles) and
// returns a one-cycle up_ack_vld/up_err/up_rd_data response to the grantee.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  native_mem_arbiter_if.master (requester lanes + memory slave bus)
module native_mem_arbiter #(
  parameter int                    NUM_REQ    = 2,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEADBEEF)
) (
  input logic                  clk,
  input logic                  rst,
  native_mem_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  idx_t                  ptr_q, ptr_d;
  idx_t                  grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  found;
  idx_t                  sel;
  logic                  sel_wr, sel_rd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;

    // Round-robin search in two passes: lanes at or above the pointer first,
    // then wrap around to the lowest set lane.
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.up_req_vld[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        sel   = idx_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.up_req_vld[i]) begin
        found = 1'b1;
        sel   = idx_t'(i);
      end
    end

    sel_wr    = 1'b0;
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == idx_t'(i)) begin
        sel_wr    = bus.up_wr_en[i];
        sel_rd    = bus.up_rd_en[i];
        sel_addr  = bus.up_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.up_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          ptr_d   = (sel == idx_t'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          wr_d    = sel_wr;
          // Both enables set is treated as a write.
          rd_d    = sel_rd & ~sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = '0;
          if (!sel_wr && !sel_rd) begin
            // No-op command never reaches the slave.
            err_d   = 1'b1;
            data_d  = ERR_DATA;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // An ack on the final count takes priority over the timeout.
        if (bus.ack_vld) begin
          data_d  = rd_q ? bus.rd_data : '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_vld    = (state_q == ISSUE);
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.addr       = '0;
    bus.wr_data    = '0;
    bus.up_rd_data = '0;
    bus.up_ack_vld = '0;
    bus.up_err     = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      bus.wr_en   = wr_q;
      bus.rd_en   = rd_q;
      bus.addr    = addr_q;
      bus.wr_data = wdata_q;
    end
    if (state_q == RESP) begin
      bus.up_rd_data = data_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.up_ack_vld[i] = (grant_q == idx_t'(i));
        bus.up_err[i]     = (grant_q == idx_t'(i)) & err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
endmodule
